// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes,
// FSM state encoding and datapath step mode.
package muldiv_sequencer_pkg;

  // Must match the ALU control unit encoding
  localparam logic [4:0] OP_MULT = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd13;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    SIGN
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the unsigned multiply/divide loop.
// mul: acc = {partial_hi, multiplier_remaining}; add |b| if lsb set, shift right.
// div: acc = {remainder, quotient}; shift left, trial-subtract |b|, restore if negative.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mode_t                mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     babs,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] shl;

  // Both step flavours computed in parallel; mode selects the result
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, babs} : {(WIDTH+1){1'b0}});
    shl   = {acc[2*WIDTH-2:0], 1'b0};
    trial = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, babs};
    if (mode == MODE_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      // Trial went negative: restore, quotient bit stays 0
      acc_next = shl;
    end else begin
      acc_next = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide sequencer owning the HI/LO register pair.
// Operands are converted to magnitudes at accept, iterated WIDTH times, and
// sign-corrected in a final SIGN cycle that commits HI/LO.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   babs;
  logic               sa;
  logic               sb;
  logic               is_div;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  mode_t              mode;

  assign busy = (state != IDLE);
  assign mode = (state == DIV) ? MODE_DIV : MODE_MUL;

  // Operand magnitudes and sign-corrected results
  always_comb begin
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;
    prod  = (sa ^ sb) ? -acc : acc;
    quo   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (mode),
    .acc     (acc),
    .babs    (babs),
    .acc_next(acc_next)
  );

  // Sequencer FSM, iteration counter and HI/LO commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      babs        <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      is_div      <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && (op == OP_MULT || op == OP_DIV)) begin
            sa          <= a[WIDTH-1];
            sb          <= b[WIDTH-1];
            babs        <= b_abs;
            count       <= CW'(WIDTH);
            is_div      <= (op == OP_DIV);
            div_by_zero <= 1'b0;
            acc         <= {{WIDTH{1'b0}}, a_abs};
            if (op == OP_MULT) begin
              state <= MUL;
            end else if (b == '0) begin
              // Keep raw a so SIGN can return it in HI
              acc         <= {{WIDTH{1'b0}}, a};
              div_by_zero <= 1'b1;
              state       <= SIGN;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL, DIV: begin
          acc   <= acc_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          if (div_by_zero) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table-driven operations with a
// scoreboard queue, plus hand sequences for busy-ignore, back-to-back,
// invalid op and mid-operation reset.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [4:0] MULT = 5'd14;
  localparam logic [4:0] DIVC = 5'd13;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  typedef struct {
    string        name;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[11];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start strobe across a single edge; operands scrambled afterwards
  task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input exp_t e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Called just after the accepting edge; waits for done with a bound
  task automatic wait_done(input string name, input int exp_lat);
    int   cyc = 0;
    exp_t e;
    check({name, " busy"}, 64'(busy), 64'd1);
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 3 && exp_lat > 3) begin
        check({name, " hi hold"}, 64'(hi), 64'(last_hi));
        check({name, " lo hold"}, 64'(lo), 64'(last_lo));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check({name, " busy at done"}, 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard: got done expected no result", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " hi"}, 64'(hi), 64'(e.hi));
      check({name, " lo"}, 64'(lo), 64'(e.lo));
      check({name, " dz"}, 64'(div_by_zero), 64'(e.dz));
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  initial begin
    exp_t e;
    int   dcount;

    vecs[0]  = '{"mul 7*-3",      MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{"mul min*min",   MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{"div -7/2",      DIVC, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{"div min/-1",    DIVC, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4]  = '{"div 5/0",       DIVC, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5]  = '{"mul 2*3",       MULT, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0, 33};
    vecs[6]  = '{"div 7/-2",      DIVC, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[7]  = '{"mul -1*-1",     MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[8]  = '{"div -100/-7",   DIVC, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33};
    vecs[9]  = '{"mul -1*max",    MULT, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33};
    vecs[10] = '{"div -8/0",      DIVC, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1};

    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dz", 64'(div_by_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.dz = vecs[i].dz;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e);
      wait_done(vecs[i].name, vecs[i].lat);
      @(posedge clk);
      #1;
      check({vecs[i].name, " done width"}, 64'(done), 64'd0);
    end

    // Start while busy is ignored; start held on the done cycle is accepted
    e = '{32'd0, 32'd16, 1'b0};
    issue(MULT, 32'd4, 32'd4, 1'b1, e);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    issue(MULT, 32'd9, 32'd9, 1'b0, e);
    wait_done("mul 4*4 busy-ignore", 27);
    e = '{32'd0, 32'd81, 1'b0};
    issue(MULT, 32'd9, 32'd9, 1'b1, e);
    check("b2b done drop", 64'(done), 64'd0);
    wait_done("mul 9*9 on done", 33);

    // Unsupported op code is ignored
    issue(5'd5, 32'd1, 32'd2, 1'b0, e);
    check("bad op busy", 64'(busy), 64'd0);

    // Reset mid-operation clears everything at once and aborts the result
    issue(MULT, 32'd4, 32'd4, 1'b0, e);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    #2;
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    dcount  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    check("midrst no done", 64'(dcount), 64'd0);
    e = '{32'd2, 32'd14, 1'b0};
    issue(DIVC, 32'd100, 32'd7, 1'b1, e);
    wait_done("div 100/7 after rst", 33);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
